// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds the S_FAULT state.
package fetch_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t DEFAULT_RESET_PC = 16'h0000;
  localparam word_t DEFAULT_PC_STEP  = 16'd2;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;
`endif

  // The PC wraps modulo 2^16 simply by the width of the result.
  function automatic word_t pc_add(input word_t pc, input word_t step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: synchronous active-low reset, load, increment.
// Reset beats load, load beats increment.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC,
  parameter word_t PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  word_t load_pc,
  input  logic  inc,
  output word_t pc
);

  // PC update with reset > load > increment priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc_add(pc, PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues memory reads at the PC and holds each
// fetched word until the downstream stage accepts it. All outputs come
// from registers. Optional macro FETCH_ALIGN_CHECK_EN traps odd PCs in
// S_FAULT instead of fetching them.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC,
  parameter word_t PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              fault
`endif
);

  state_t state;
  state_t state_next;
  word_t  pc;
  logic   capture;
  logic   pc_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign pc_misaligned = pc[0];
  assign fault         = (state == S_FAULT);
`else
  assign pc_misaligned = 1'b0;
`endif

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk     (CLK),
    .rst_n   (RST_N),
    .load    (redirect),
    .load_pc (redirect_pc),
    .inc     (capture),
    .pc      (pc)
  );

  // State register; reset returns to idle and abandons any request.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a redirect overrides everything, including a same-cycle ack.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (pc_misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
          state_next = S_FAULT;
`else
          state_next = S_REQ;
`endif
        end else if (mem_ack) begin
          state_next = S_HOLD;
          capture    = 1'b1;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          state_next = S_REQ;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_FAULT: state_next = S_FAULT;
`endif
      default: state_next = S_IDLE;
    endcase
    if (redirect) begin
      state_next = S_REQ;
      capture    = 1'b0;
    end
  end

  // Instruction output registers capture the word and its address on a completed fetch.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      instr_out <= '0;
      instr_pc  <= '0;
    end else if (capture) begin
      instr_out <= mem_rdata;
      instr_pc  <= pc;
    end
  end

  assign mem_req     = (state == S_REQ) && !pc_misaligned;
  assign mem_addr    = pc;
  assign instr_valid = (state == S_HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vectors, a transaction-level
// reference model compared every cycle, and literal spot checks.
module tb_fetch_unit;

  logic        CLK;
  logic        RST_N;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault;
`endif

  int errors = 0;
  int checks = 0;

  fetch_unit #(
    .RESET_PC (16'h0000),
    .PC_STEP  (16'd2)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fault       (fault)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: what the fetcher has (a held word or not), where it fetches next.
  logic        model_valid = 1'b0;
  logic        m_started   = 1'b0;
  logic        m_have      = 1'b0;
  logic        m_fault     = 1'b0;
  logic [15:0] m_pc        = 16'h0000;
  logic [15:0] m_instr     = 16'h0000;
  logic [15:0] m_ipc       = 16'h0000;

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_pc = 16'h0000; m_started = 1'b0; m_have = 1'b0; m_fault = 1'b0;
      m_instr = 16'h0000; m_ipc = 16'h0000; model_valid = 1'b1;
    end else if (redirect) begin
      m_pc = redirect_pc; m_started = 1'b1; m_have = 1'b0; m_fault = 1'b0;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_have) begin
      if (instr_ready) m_have = 1'b0;
    end else if (m_fault) begin
      m_fault = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
    end else if (m_pc[0]) begin
      m_fault = 1'b1;
`endif
    end else if (mem_ack) begin
      m_instr = mem_rdata; m_ipc = m_pc; m_pc = m_pc + 16'd2; m_have = 1'b1;
    end
  end

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (model_valid) begin
      logic exp_req;
      exp_req = m_started && !m_have && !m_fault;
`ifdef FETCH_ALIGN_CHECK_EN
      if (m_pc[0]) exp_req = 1'b0;
      check_output("model.fault", {15'd0, fault}, {15'd0, m_fault});
`endif
      check_output("model.mem_req", {15'd0, mem_req}, {15'd0, exp_req});
      check_output("model.mem_addr", mem_addr, m_pc);
      check_output("model.instr_valid", {15'd0, instr_valid}, {15'd0, m_have});
      check_output("model.instr_out", instr_out, m_instr);
      check_output("model.instr_pc", instr_pc, m_ipc);
    end
  end

  // Drive one cycle of inputs, then return just after the clock edge that consumes them.
  task automatic apply_stimulus(input logic rn, input logic ack, input logic [15:0] rdata,
                                input logic rdy, input logic rdr, input logic [15:0] rpc);
    RST_N       = rn;
    mem_ack     = ack;
    mem_rdata   = rdata;
    instr_ready = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset values
    apply_stimulus(0, 0, 16'h0000, 0, 0, 16'h0000);
    apply_stimulus(0, 1, 16'h9999, 1, 0, 16'h0000);
    check_output("rst.mem_req", {15'd0, mem_req}, 16'd0);
    check_output("rst.mem_addr", mem_addr, 16'h0000);
    check_output("rst.instr_valid", {15'd0, instr_valid}, 16'd0);
    check_output("rst.instr_out", instr_out, 16'h0000);
    check_output("rst.instr_pc", instr_pc, 16'h0000);

    // First fetch, ack one cycle after the request
    apply_stimulus(1, 0, 16'h0000, 0, 0, 16'h0000);
    check_output("f1.mem_req", {15'd0, mem_req}, 16'd1);
    check_output("f1.mem_addr", mem_addr, 16'h0000);
    apply_stimulus(1, 0, 16'h0000, 0, 0, 16'h0000);
    check_output("f1.wait_addr", mem_addr, 16'h0000);
    apply_stimulus(1, 1, 16'hABCD, 0, 0, 16'h0000);
    check_output("f1.instr_valid", {15'd0, instr_valid}, 16'd1);
    check_output("f1.instr_out", instr_out, 16'hABCD);
    check_output("f1.instr_pc", instr_pc, 16'h0000);
    check_output("f1.next_addr", mem_addr, 16'h0002);

    // Backpressure for 3 cycles; a stray ack during hold is ignored
    apply_stimulus(1, 1, 16'hFFFF, 0, 0, 16'h0000);
    check_output("hold1.instr_out", instr_out, 16'hABCD);
    apply_stimulus(1, 0, 16'h0000, 0, 0, 16'h0000);
    check_output("hold2.mem_req", {15'd0, mem_req}, 16'd0);
    apply_stimulus(1, 0, 16'h0000, 0, 0, 16'h0000);
    check_output("hold3.instr_valid", {15'd0, instr_valid}, 16'd1);
    check_output("hold3.instr_out", instr_out, 16'hABCD);
    apply_stimulus(1, 0, 16'h0000, 1, 0, 16'h0000);
    check_output("accept.mem_req", {15'd0, mem_req}, 16'd1);
    check_output("accept.mem_addr", mem_addr, 16'h0002);

    // Second fetch with immediate ack
    apply_stimulus(1, 1, 16'h1111, 0, 0, 16'h0000);
    check_output("f2.instr_pc", instr_pc, 16'h0002);
    apply_stimulus(1, 0, 16'h0000, 1, 0, 16'h0000);
    check_output("f2.next_addr", mem_addr, 16'h0004);

    // Redirect in the same cycle as ack discards the data
    apply_stimulus(1, 1, 16'hDEAD, 0, 1, 16'h1234);
    check_output("redir.instr_valid", {15'd0, instr_valid}, 16'd0);
    check_output("redir.mem_addr", mem_addr, 16'h1234);
    check_output("redir.instr_out", instr_out, 16'h1111);
    apply_stimulus(1, 1, 16'h2222, 0, 0, 16'h0000);
    check_output("redir.f_pc", instr_pc, 16'h1234);

    // Redirect beats instr_ready; then fetch at the top of memory wraps
    apply_stimulus(1, 0, 16'h0000, 1, 1, 16'hFFFE);
    check_output("wrap.mem_addr", mem_addr, 16'hFFFE);
    apply_stimulus(1, 1, 16'h5A5A, 0, 0, 16'h0000);
    check_output("wrap.instr_pc", instr_pc, 16'hFFFE);
    check_output("wrap.next_addr", mem_addr, 16'h0000);
    apply_stimulus(1, 0, 16'h0000, 1, 0, 16'h0000);
    check_output("wrap.mem_req", {15'd0, mem_req}, 16'd1);

    // Reset while awaiting ack; the late ack must be ignored
    apply_stimulus(0, 0, 16'h0000, 0, 0, 16'h0000);
    check_output("midrst.mem_req", {15'd0, mem_req}, 16'd0);
    check_output("midrst.instr_out", instr_out, 16'h0000);
    apply_stimulus(1, 1, 16'h7777, 0, 0, 16'h0000);
    check_output("midrst.instr_valid", {15'd0, instr_valid}, 16'd0);
    check_output("midrst.mem_addr", mem_addr, 16'h0000);
    apply_stimulus(1, 0, 16'h0000, 0, 0, 16'h0000);
    check_output("midrst.instr_out2", instr_out, 16'h0000);

`ifdef FETCH_ALIGN_CHECK_EN
    // Odd PC traps until redirected to an aligned address
    apply_stimulus(1, 0, 16'h0000, 0, 1, 16'h0101);
    check_output("align.req_odd", {15'd0, mem_req}, 16'd0);
    apply_stimulus(1, 1, 16'h3333, 0, 0, 16'h0000);
    check_output("align.fault", {15'd0, fault}, 16'd1);
    apply_stimulus(1, 0, 16'h0000, 1, 0, 16'h0000);
    check_output("align.fault_held", {15'd0, fault}, 16'd1);
    apply_stimulus(1, 0, 16'h0000, 0, 1, 16'h0100);
    check_output("align.fault_clr", {15'd0, fault}, 16'd0);
    check_output("align.mem_addr", mem_addr, 16'h0100);
`else
    // Odd PCs are fetched normally without the alignment check
    apply_stimulus(1, 0, 16'h0000, 0, 1, 16'h0101);
    check_output("odd.mem_req", {15'd0, mem_req}, 16'd1);
    check_output("odd.mem_addr", mem_addr, 16'h0101);
    apply_stimulus(1, 1, 16'hBEEF, 0, 0, 16'h0000);
    check_output("odd.instr_pc", instr_pc, 16'h0101);
    check_output("odd.next_addr", mem_addr, 16'h0103);
`endif

    // A couple of back-to-back fetches to finish
    apply_stimulus(1, 0, 16'h0000, 1, 0, 16'h0000);
    apply_stimulus(1, 1, 16'h4444, 1, 0, 16'h0000);
    apply_stimulus(1, 0, 16'h0000, 1, 0, 16'h0000);
    apply_stimulus(1, 1, 16'h5555, 0, 0, 16'h0000);
    apply_stimulus(1, 0, 16'h0000, 0, 0, 16'h0000);
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded at reset.
REQ-002 SHALL have parameter PC_STEP, default 16'd2, the PC increment per fetched instruction.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST_N  input  1  synchronous active-low reset.
REQ-006 mem_req  output  1  memory read request.
REQ-007 mem_addr  output  16  read address, equal to the current PC.
REQ-008 mem_ack  input  1  read data valid; completes the request.
REQ-009 mem_rdata  input  16  instruction word, sampled when mem_ack=1.
REQ-010 instr_valid  output  1  instr_out/instr_pc hold a valid instruction for the downstream instruction register.
REQ-011 instr_ready  input  1  downstream accepts the instruction.
REQ-012 instr_out  output  16  fetched instruction word.
REQ-013 instr_pc  output  16  address the instruction was fetched from.
REQ-014 redirect  input  1  load a new PC and discard any in-flight work.
REQ-015 redirect_pc  input  16  target PC, sampled when redirect=1.
REQ-016 fault  output  1  misaligned-PC fault (present only under FETCH_ALIGN_CHECK_EN).

Function
REQ-017 SHALL implement states S_IDLE, S_REQ, S_HOLD, plus S_FAULT under FETCH_ALIGN_CHECK_EN.
REQ-018 SHALL drive all outputs from registers/state only; there SHALL be no combinational path from any input to any output.
REQ-019 S_IDLE: mem_req=0, instr_valid=0; next state S_REQ unconditionally.
REQ-020 S_REQ: mem_req=1, mem_addr=PC, held stable until mem_ack; mem_ack=1 -> instr_out<=mem_rdata, instr_pc<=PC, PC<=PC+PC_STEP (mod 2^16), go to S_HOLD.
REQ-021 Fetch latency: mem_ack sampled high in cycle N -> instr_valid=1 in cycle N+1.
REQ-022 S_HOLD: instr_valid=1, mem_req=0, instr_out/instr_pc stable; instr_ready=1 -> S_REQ next cycle; otherwise stay.
REQ-023 mem_ack SHALL be ignored in every state other than S_REQ.
REQ-024 PC wrap: 16'hFFFE + 2 SHALL yield 16'h0000 with no other effect.
REQ-025 redirect=1 in any state: PC<=redirect_pc, instr_valid cleared, next state S_REQ; the fetch SHALL be discarded even if mem_ack=1 in the same cycle.
REQ-026 redirect SHALL take priority over mem_ack and over instr_ready; RST_N=0 SHALL take priority over everything.

Reset
REQ-027 On RST_N=0 at a CLK edge: state=S_IDLE, PC=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, fault=0.
REQ-028 Reset mid-transaction SHALL abandon the request; an mem_ack arriving after reset SHALL be ignored.

Configuration
REQ-029 Macro FETCH_ALIGN_CHECK_EN SHALL, when defined, make S_REQ with PC[0]=1 skip the request (mem_req=0) and enter S_FAULT, where fault=1 stays asserted until redirect or reset.
REQ-030 Without FETCH_ALIGN_CHECK_EN, the fault port, the S_FAULT state and the check SHALL be absent, and odd PCs SHALL be fetched normally.

Structure
REQ-031 Package fetch_pkg SHALL hold the state-encoding typedef, the default RESET_PC and PC_STEP constants and the 16-bit word width.
REQ-032 The PC SHALL be a sub-module fetch_pc_reg (load, increment, reset value); the FSM and output registers SHALL live in fetch_unit.

Verification
REQ-033 Reset, then mem_ack=1 one cycle after mem_req with mem_rdata=16'hABCD -> mem_addr=16'h0000, next cycle instr_valid=1, instr_out=16'hABCD, instr_pc=16'h0000, then mem_addr=16'h0002.
REQ-034 Hold instr_ready=0 for 3 cycles -> instr_valid and instr_out held stable and mem_req=0; instr_ready=1 -> mem_req=1 next cycle.
REQ-035 redirect=1 with redirect_pc=16'h1234 in the same cycle as mem_ack -> data discarded, instr_valid=0, next mem_addr=16'h1234.
REQ-036 PC=16'hFFFE, fetch completes -> instr_pc=16'hFFFE, next mem_addr=16'h0000.
REQ-037 RST_N=0 while mem_req=1 and awaiting ack, then ack arrives -> all outputs at reset values, ack ignored, fetch restarts at RESET_PC.
REQ-038 FETCH_ALIGN_CHECK_EN defined, redirect_pc=16'h0101 -> fault=1, mem_req=0; redirect to 16'h0100 -> fault=0, mem_addr=16'h0100.
